rlbp_readout_seq: RTL

//  Readout sequencer for the analog RLBP front-end (SystemLevel macro). Drives the

---
 rtl/rlbp_readout_seq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/rlbp_readout_seq.sv
// Readout sequencer for the RLBP analog front-end: scans N_PIX photodiode pairs and builds an LBP code.
// Optional RLBP_CMP_SYNC_EN: 2-flop cmp synchronizer, with the CMP phase lengthened by 2 cycles.
module rlbp_readout_seq #(
  parameter int N_PIX = 12,
  parameter int CNT_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] t_rst,
  input  logic [CNT_W-1:0] t_int,
  input  logic [CNT_W-1:0] t_sh,
  input  logic [CNT_W-1:0] t_cmp,
  input  logic             vref_sel_i,
  input  logic             cmp,
  output logic [N_PIX-1:0] pd_a,
  output logic [N_PIX-1:0] pd_b,
  output logic             vd1,
  output logic             vd2,
  output logic             sw1,
  output logic             sw2,
  output logic             sh,
  output logic             sh_cmp,
  output logic             sh_rst,
  output logic [4:0]       tg_sel,
  output logic             vref_sel,
  output logic             busy,
  output logic             done,
  output logic [N_PIX-1:0] code,
  output logic             code_valid
);
  localparam int IW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [CNT_W:0] ONE_C = (CNT_W+1)'(1);
  localparam logic [IW-1:0] ONE_I = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PIX - 1);
  localparam logic [4:0] TG_OTA_OUT  = 5'b00001;
  localparam logic [4:0] TG_CMP_OUT  = 5'b00100;
  localparam logic [4:0] TG_OTA_SH   = 5'b01000;
  localparam logic [4:0] TG_VREF_CMP = 5'b10000;

  typedef enum logic [2:0] {S_IDLE, S_RST, S_INTEG, S_SH, S_CMP, S_LATCH, S_DONE} state_t;

  logic cmp_s;
`ifdef RLBP_CMP_SYNC_EN
  localparam logic [CNT_W:0] CMP_EXTRA = (CNT_W+1)'(2);
  logic cmp_meta_q, cmp_sync_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmp_meta_q <= 1'b0;
      cmp_sync_q <= 1'b0;
    end else begin
      cmp_meta_q <= cmp;
      cmp_sync_q <= cmp_meta_q;
    end
  end
  assign cmp_s = cmp_sync_q;
`else
  localparam logic [CNT_W:0] CMP_EXTRA = '0;
  assign cmp_s = cmp;
`endif

  // Counter load value for a phase of max(t,1)+extra cycles.
  function automatic logic [CNT_W:0] load_len(input logic [CNT_W-1:0] t, input logic [CNT_W:0] extra);
    logic [CNT_W:0] len;
    len = (t == '0) ? ONE_C : {1'b0, t};
    return len + extra - ONE_C;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] t_rst_q, t_rst_d, t_int_q, t_int_d, t_sh_q, t_sh_d, t_cmp_q, t_cmp_d;
  logic [N_PIX-1:0] code_q, code_d, pd_q, pd_d;
  logic             code_valid_q, code_valid_d, busy_q, busy_d, done_q, done_d;
  logic             vd1_q, vd1_d, vd2_q, vd2_d, sw1_q, sw1_d, sw2_q, sw2_d;
  logic             sh_q, sh_d, sh_cmp_q, sh_cmp_d, sh_rst_q, sh_rst_d, vref_sel_q, vref_sel_d;
  logic [4:0]       tg_sel_q, tg_sel_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    t_rst_d      = t_rst_q;
    t_int_d      = t_int_q;
    t_sh_d       = t_sh_q;
    t_cmp_d      = t_cmp_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d      = S_RST;
        cnt_d        = load_len(t_rst, '0);
        idx_d        = '0;
        code_valid_d = 1'b0;
        t_rst_d      = t_rst;
        t_int_d      = t_int;
        t_sh_d       = t_sh;
        t_cmp_d      = t_cmp;
      end
      S_RST:   if (cnt_q == '0) begin state_d = S_INTEG; cnt_d = load_len(t_int_q, '0); end
               else cnt_d = cnt_q - ONE_C;
      S_INTEG: if (cnt_q == '0) begin state_d = S_SH; cnt_d = load_len(t_sh_q, '0); end
               else cnt_d = cnt_q - ONE_C;
      S_SH:    if (cnt_q == '0) begin state_d = S_CMP; cnt_d = load_len(t_cmp_q, CMP_EXTRA); end
               else cnt_d = cnt_q - ONE_C;
      S_CMP:   if (cnt_q == '0) state_d = S_LATCH;
               else cnt_d = cnt_q - ONE_C;
      S_LATCH: begin
        code_d[idx_q] = cmp_s;
        if (idx_q == LAST_IDX) begin
          state_d      = S_DONE;
          idx_d        = '0;
          code_valid_d = 1'b1;
        end else begin
          state_d = S_RST;
          idx_d   = idx_q + ONE_I;
          cnt_d   = load_len(t_rst_q, '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      idx_d        = '0;
      code_valid_d = 1'b0;
    end

    pd_d       = '0;
    vd1_d      = 1'b0;
    vd2_d      = 1'b0;
    sw1_d      = 1'b0;
    sw2_d      = 1'b0;
    sh_d       = 1'b0;
    sh_cmp_d   = 1'b0;
    sh_rst_d   = 1'b0;
    tg_sel_d   = TG_OTA_OUT;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    vref_sel_d = vref_sel_i;
    case (state_d)
      S_RST:   begin sw1_d = 1'b1; sh_rst_d = 1'b1; end
      S_INTEG: begin sw2_d = 1'b1; vd2_d = 1'b1; end
      S_SH:    begin sh_d = 1'b1; tg_sel_d = TG_OTA_SH; end
      S_CMP:   begin sh_cmp_d = 1'b1; tg_sel_d = TG_CMP_OUT; end
      S_LATCH: tg_sel_d = TG_VREF_CMP;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
    if (state_d inside {S_RST, S_INTEG, S_SH, S_CMP, S_LATCH}) begin
      busy_d = 1'b1;
      vd1_d  = 1'b1;
      pd_d   = {{(N_PIX-1){1'b0}}, 1'b1} << idx_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      t_rst_q      <= '0;
      t_int_q      <= '0;
      t_sh_q       <= '0;
      t_cmp_q      <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      pd_q         <= '0;
      vd1_q        <= 1'b0;
      vd2_q        <= 1'b0;
      sw1_q        <= 1'b0;
      sw2_q        <= 1'b0;
      sh_q         <= 1'b0;
      sh_cmp_q     <= 1'b0;
      sh_rst_q     <= 1'b0;
      tg_sel_q     <= TG_OTA_OUT;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vref_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      t_rst_q      <= t_rst_d;
      t_int_q      <= t_int_d;
      t_sh_q       <= t_sh_d;
      t_cmp_q      <= t_cmp_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      pd_q         <= pd_d;
      vd1_q        <= vd1_d;
      vd2_q        <= vd2_d;
      sw1_q        <= sw1_d;
      sw2_q        <= sw2_d;
      sh_q         <= sh_d;
      sh_cmp_q     <= sh_cmp_d;
      sh_rst_q     <= sh_rst_d;
      tg_sel_q     <= tg_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vref_sel_q   <= vref_sel_d;
    end
  end

  assign pd_a       = pd_q;
  assign pd_b       = pd_q;
  assign vd1        = vd1_q;
  assign vd2        = vd2_q;
  assign sw1        = sw1_q;
  assign sw2        = sw2_q;
  assign sh         = sh_q;
  assign sh_cmp     = sh_cmp_q;
  assign sh_rst     = sh_rst_q;
  assign tg_sel     = tg_sel_q;
  assign vref_sel   = vref_sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;
endmodule
